// File: rtl/arb_pkg.sv
// Shared types and widths for the one-hot round-robin arbiter.
package arb_pkg;

  localparam int REQ_W = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping 15->0.
module rr_pick
  import arb_pkg::*;
(
  input  logic [REQ_W-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [REQ_W-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand_s;

  // Scan downward in offset so the smallest offset from ptr is the last to win.
  always_comb begin
    idx    = {IDX_W{1'b0}};
    cand_s = {IDX_W{1'b0}};
    any    = |req;
    for (int i = REQ_W - 1; i >= 0; i--) begin
      cand_s = ptr + IDX_W'(i);
      idx    = req[cand_s] ? cand_s : idx;
    end
    gnt = any ? ({{(REQ_W-1){1'b0}}, 1'b1} << idx) : {REQ_W{1'b0}};
  end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant and valid/ready handshake.
// Define ONEHOT_ARB_IDX_EN to add the registered binary grant_idx output.
module onehot_rr_arbiter
  import arb_pkg::*;
#(
  parameter logic [IDX_W-1:0] PTR_RESET = 4'd0
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REQ_W-1:0] req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [REQ_W-1:0] grant_onehot
`ifdef ONEHOT_ARB_IDX_EN
  ,
  output logic [IDX_W-1:0] grant_idx
`endif
);

  state_e           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] nxt_ptr_q;
  logic [REQ_W-1:0] grant_q;
`ifdef ONEHOT_ARB_IDX_EN
  logic [IDX_W-1:0] idx_q;
`endif

  logic             hs_s;
  logic [IDX_W-1:0] ptr_sel_s;
  logic [REQ_W-1:0] pick_gnt_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_any_s;

  // On a handshake the pick must already use the advanced pointer to avoid a bubble.
  always_comb begin
    hs_s = (state_q == HOLD) && out_ready;
    if (hs_s) begin
      ptr_sel_s = nxt_ptr_q;
    end else begin
      ptr_sel_s = ptr_q;
    end
  end

  rr_pick u_pick (
    .req (req),
    .ptr (ptr_sel_s),
    .gnt (pick_gnt_s),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  // Grant FSM: nxt_ptr_q remembers granted index + 1 so the pointer advances only on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_RESET;
      nxt_ptr_q <= PTR_RESET;
      grant_q   <= {REQ_W{1'b0}};
`ifdef ONEHOT_ARB_IDX_EN
      idx_q     <= {IDX_W{1'b0}};
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any_s) begin
            state_q   <= HOLD;
            grant_q   <= pick_gnt_s;
            nxt_ptr_q <= pick_idx_s + 4'd1;
`ifdef ONEHOT_ARB_IDX_EN
            idx_q     <= pick_idx_s;
`endif
          end else begin
            state_q <= IDLE;
            grant_q <= {REQ_W{1'b0}};
          end
        end
        HOLD: begin
          if (hs_s) begin
            ptr_q <= nxt_ptr_q;
            if (pick_any_s) begin
              state_q   <= HOLD;
              grant_q   <= pick_gnt_s;
              nxt_ptr_q <= pick_idx_s + 4'd1;
`ifdef ONEHOT_ARB_IDX_EN
              idx_q     <= pick_idx_s;
`endif
            end else begin
              state_q <= IDLE;
              grant_q <= {REQ_W{1'b0}};
`ifdef ONEHOT_ARB_IDX_EN
              idx_q   <= {IDX_W{1'b0}};
`endif
            end
          end else begin
            state_q <= HOLD;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= {REQ_W{1'b0}};
        end
      endcase
    end
  end

  assign out_valid    = (state_q == HOLD);
  assign grant_onehot = grant_q;
`ifdef ONEHOT_ARB_IDX_EN
  assign grant_idx    = idx_q;
`endif

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Randomized bench for onehot_rr_arbiter against a queue-free behavioural round-robin model.
module tb_onehot_rr_arbiter;

  localparam int PTR_RST = 0;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] grant_onehot;
`ifdef ONEHOT_ARB_IDX_EN
  logic [3:0]  grant_idx;
`endif

  onehot_rr_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .grant_onehot (grant_onehot)
`ifdef ONEHOT_ARB_IDX_EN
    ,
    .grant_idx    (grant_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Model state: whether a grant is shown, which index, and the priority pointer.
  bit m_valid;
  int m_g;
  int m_ptr;
  int m_hs_idx;
  int wait_cnt [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int pick(input logic [15:0] r, input int p);
    for (int k = 0; k < 16; k++) begin
      if (r[(p + k) % 16]) return (p + k) % 16;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_g     = 0;
    m_ptr   = PTR_RST;
    for (int i = 0; i < 16; i++) wait_cnt[i] = 0;
  endtask

  // One clock: predict from current inputs, clock, then compare DUT to the model.
  task automatic step();
    bit nv;
    int ng;
    int np;
    bit hs;
    nv = m_valid; ng = m_g; np = m_ptr;
    hs = m_valid && out_ready && rst_n;
    m_hs_idx = -1;
    for (int i = 0; i < 16; i++) if (!req[i]) wait_cnt[i] = 0;
    if (!rst_n) begin
      nv = 1'b0; ng = 0; np = PTR_RST;
      for (int i = 0; i < 16; i++) wait_cnt[i] = 0;
    end else if (!m_valid || hs) begin
      if (hs) begin
        np = (m_g + 1) % 16;
        m_hs_idx = m_g;
        for (int i = 0; i < 16; i++) begin
          if (i == m_g) wait_cnt[i] = 0;
          else if (req[i]) begin
            wait_cnt[i]++;
            check($sformatf("starve_%0d", i), (wait_cnt[i] < 16) ? 32'd1 : 32'd0, 32'd1);
          end
        end
      end
      if (req != 16'h0) begin nv = 1'b1; ng = pick(req, np); end
      else nv = 1'b0;
    end
    @(posedge clk); #1;
    m_valid = nv; m_g = ng; m_ptr = np;
    check("valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("grant", {16'd0, grant_onehot}, m_valid ? (32'd1 << m_g) : 32'd0);
    if (out_valid) check("onehot", {31'd0, $onehot(grant_onehot)}, 32'd1);
`ifdef ONEHOT_ARB_IDX_EN
    check("idx", {28'd0, grant_idx}, m_valid ? m_g : 32'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; req = 16'h0; out_ready = 1'b0;
    model_reset();
    #3;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_grant", {16'd0, grant_onehot}, 32'd0);
    repeat (2) step();
    #2 rst_n = 1'b1;

    // Single requester, immediate handshake.
    req = 16'h0001; out_ready = 1'b1; step();
    check("s024_valid", {31'd0, out_valid}, 32'd1);
    check("s024_grant", {16'd0, grant_onehot}, 32'h0001);
    req = 16'h0000; step();
    check("s024_idle", {31'd0, out_valid}, 32'd0);

    // Fresh reset so the alternation starts from pointer 0.
    rst_n = 1'b0; step(); #2 rst_n = 1'b1;
    req = 16'h8001; out_ready = 1'b1;
    step(); check("s025_a", {16'd0, grant_onehot}, 32'h0001);
    step(); check("s025_b", {16'd0, grant_onehot}, 32'h8000);
    step(); check("s025_c", {16'd0, grant_onehot}, 32'h0001);
    req = 16'h8000; step(); check("s026_a", {16'd0, grant_onehot}, 32'h8000);
    req = 16'h0006; step(); check("s026_wrap", {16'd0, grant_onehot}, 32'h0002);
    req = 16'h0000; step();

    // Stall with changing requests.
    req = 16'h0010; out_ready = 1'b0; step();
    check("s027_grant", {16'd0, grant_onehot}, 32'h0010);
    req = 16'h0100;
    repeat (5) begin
      step();
      check("s027_hold", {16'd0, grant_onehot}, 32'h0010);
    end
    out_ready = 1'b1; step();
    check("s027_next", {16'd0, grant_onehot}, 32'h0100);
    out_ready = 1'b0; step();

    // Asynchronous reset in HOLD; pointer was 5 beforehand.
    #2 rst_n = 1'b0;
    #1;
    check("s028_valid", {31'd0, out_valid}, 32'd0);
    check("s028_grant", {16'd0, grant_onehot}, 32'd0);
    model_reset();
    step();
    #2 rst_n = 1'b1;
    req = 16'hFFFF; out_ready = 1'b1; step();
    check("s028_ptr", {16'd0, grant_onehot}, 32'h0001);

    // Fully random requests and ready.
    for (int c = 0; c < 3000; c++) begin
      req = 16'($urandom() & $urandom());
      if ($urandom_range(0, 7) == 0) req = 16'h0;
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Sticky requests held until served, to exercise the fairness bound.
    req = 16'h0;
    for (int c = 0; c < 6500; c++) begin
      if (m_hs_idx >= 0) req[m_hs_idx] = 1'b0;
      if ($urandom_range(0, 1) == 0) req[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 63) == 0) req[$urandom_range(0, 15)] = 1'b0;
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
